// File: rtl/iob_cache_line_fill.sv
// Back-end read engine for cache line refill: one IOb read per BE word of the
// line, in order, with each returned beat tagged by its word index.
module iob_cache_line_fill #(
   parameter int unsigned FE_ADDR_W     = 24,
   parameter int unsigned FE_DATA_W     = 32,
   parameter int unsigned BE_ADDR_W     = 24,
   parameter int unsigned BE_DATA_W     = 32,
   parameter int unsigned WORD_OFFSET_W = 3,
   localparam int unsigned BE_NBYTES_W  = $clog2(BE_DATA_W / 8),
   localparam int unsigned LINE2BE_W    = WORD_OFFSET_W - $clog2(BE_DATA_W / FE_DATA_W),
   localparam int unsigned TAG_W        = FE_ADDR_W - BE_NBYTES_W - LINE2BE_W
) (
   input  logic                 clk_i,
   input  logic                 arst_i,
   input  logic                 read_req_i,
   input  logic [TAG_W-1:0]     read_req_addr_i,
   output logic                 busy_o,
   output logic                 read_valid_o,
   output logic [LINE2BE_W-1:0] read_addr_o,
   output logic [BE_DATA_W-1:0] read_rdata_o,
   output logic                 be_iob_avalid_o,
   output logic [BE_ADDR_W-1:0] be_iob_addr_o,
   input  logic                 be_iob_ready_i,
   input  logic                 be_iob_rvalid_i,
   input  logic [BE_DATA_W-1:0] be_iob_rdata_i
);

   // A line must span at least two back-end words.
   if ((int'(WORD_OFFSET_W) - $clog2(BE_DATA_W / FE_DATA_W)) < 1) begin : g_bad_line
      $error("iob_cache_line_fill: line must hold at least two back-end words");
   end

   localparam logic [LINE2BE_W-1:0] LAST_WORD = '1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [LINE2BE_W-1:0]   r_cnt;
   logic [LINE2BE_W-1:0]   w_cnt_nxt;
   logic [TAG_W-1:0]       r_base;
   logic [TAG_W-1:0]       w_base_nxt;
   logic                   r_busy;
   logic                   r_avalid;
   logic [BE_ADDR_W-1:0]   r_addr;
   logic [BE_ADDR_W-1:0]   w_addr_nxt;
   logic                   w_read_valid;

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_base   <= '0;
         r_busy   <= 1'b0;
         r_avalid <= 1'b0;
         r_addr   <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_base   <= w_base_nxt;
         r_busy   <= (w_state_nxt != S_IDLE);
         r_avalid <= (w_state_nxt == S_REQ);
         r_addr   <= w_addr_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_base_nxt   = r_base;
      w_read_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (read_req_i) begin
               w_base_nxt  = read_req_addr_i;
               w_cnt_nxt   = '0;
               w_state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            if (be_iob_ready_i) begin
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            // Only the single outstanding response is accepted as a beat.
            if (be_iob_rvalid_i) begin
               w_read_valid = 1'b1;
               if (r_cnt == LAST_WORD) begin
                  w_state_nxt = S_IDLE;
               end else begin
                  w_cnt_nxt   = r_cnt + LINE2BE_W'(1);
                  w_state_nxt = S_REQ;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign w_addr_nxt = BE_ADDR_W'({w_base_nxt, w_cnt_nxt, BE_NBYTES_W'(0)});

   assign busy_o          = r_busy;
   assign be_iob_avalid_o = r_avalid;
   assign be_iob_addr_o   = r_addr;
   assign read_valid_o    = w_read_valid;
   assign read_addr_o     = r_cnt;
   assign read_rdata_o    = be_iob_rdata_i;

endmodule
